mux2_rr_arbiter: RTL and testbench

- Two-requester round-robin arbiter that owns the select line of the shared 2:1 data mux.
- Each requester raises req with its data. The arbiter grants one requester at a time and steers the mux to it.
- It registers the selected data with a valid strobe for the downstream consumer.
- A bounded hold counter stops one requester from starving the other while both are requesting.

---
 rtl/mux_arb_pkg.sv | 18 +
 rtl/mux_2_1.sv | 11 +
 rtl/mux2_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter:
// state encoding, default hold limit and hold counter sizing.
package mux_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } arb_state_e;

   localparam int DEFAULT_MAX_HOLD = 4;

   // One spare bit keeps MAX_HOLD=1 at a legal, nonzero width.
   function automatic int hold_cnt_width(input int max_hold);
      return $clog2(max_hold) + 1;
   endfunction

endpackage

// File: rtl/mux_2_1.sv
// Single-bit 2:1 multiplexer; s=0 passes i0, s=1 passes i1.
module mux_2_1 (
   input  logic i0,
   input  logic i1,
   input  logic s,
   output logic y
);

   assign y = s ? i1 : i0;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 2:1 data mux, with a
// bounded hold counter that forces rotation while both requesters wait.
module mux2_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int WIDTH    = 1,
   parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             sel,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   localparam int CW = hold_cnt_width(MAX_HOLD);
   localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

   arb_state_e       state_q, state_d;
   logic [CW-1:0]    hold_cnt_q, hold_cnt_d;
   logic             last_q, last_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [WIDTH-1:0] mux_y;
   logic             grant_hit;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         hold_cnt_q  <= '0;
         last_q      <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         last_q      <= last_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   // last_q records the requester most recently released; the other wins a tie.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      last_d     = last_q;
      case (state_q)
         IDLE: begin
            if (req0 && (!req1 || last_q)) begin
               state_d    = G0;
               hold_cnt_d = '0;
            end else if (req1) begin
               state_d    = G1;
               hold_cnt_d = '0;
            end
         end
         G0: begin
            if (!req0) begin
               last_d     = 1'b0;
               hold_cnt_d = '0;
               state_d    = req1 ? G1 : IDLE;
            end else if (req1 && (hold_cnt_q == HOLD_LAST)) begin
               last_d     = 1'b0;
               hold_cnt_d = '0;
               state_d    = G1;
            end else if (hold_cnt_q != HOLD_LAST) begin
               hold_cnt_d = hold_cnt_q + CW'(1);
            end
         end
         G1: begin
            if (!req1) begin
               last_d     = 1'b1;
               hold_cnt_d = '0;
               state_d    = req0 ? G0 : IDLE;
            end else if (req0 && (hold_cnt_q == HOLD_LAST)) begin
               last_d     = 1'b1;
               hold_cnt_d = '0;
               state_d    = G0;
            end else if (hold_cnt_q != HOLD_LAST) begin
               hold_cnt_d = hold_cnt_q + CW'(1);
            end
         end
         default: begin
            state_d    = IDLE;
            hold_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      gnt0 = (state_q == G0);
      gnt1 = (state_q == G1);
      sel  = (state_q == G1);
   end

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mux
      mux_2_1 u_mux (
         .i0 (d0[gi]),
         .i1 (d1[gi]),
         .s  (sel),
         .y  (mux_y[gi])
      );
   end

   // A grant only yields a sample while its owner is still requesting.
   always_comb begin
      grant_hit   = ((state_q == G0) && req0) || ((state_q == G1) && req1);
      out_valid_d = grant_hit;
      out_data_d  = grant_hit ? mux_y : out_data_q;
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench: directed vector table, hand-written rotation/reset
// sequences, then constrained-random traffic against an ownership model.
module tb_mux2_rr_arbiter;

   localparam int W        = 8;
   localparam int MAX_HOLD = 4;

   logic         clk = 1'b0;
   logic         rst_n, req0, req1;
   logic [W-1:0] d0, d1;
   logic         gnt0, gnt1, sel, out_valid;
   logic [W-1:0] out_data;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: owner -1 means nobody; run counts cycles of the current grant.
   int           m_owner;
   int           m_run;
   int           m_last;
   logic         m_ov;
   logic [W-1:0] m_od;

   typedef struct {
      logic         rst, q0, q1;
      logic [W-1:0] a, b;
      logic         e0, e1, ev;
      logic [W-1:0] eo;
   } vec_t;

   vec_t tbl[24];

   mux2_rr_arbiter #(.WIDTH(W), .MAX_HOLD(MAX_HOLD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0      (req0),
      .req1      (req1),
      .d0        (d0),
      .d1        (d1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .sel       (sel),
      .out_valid (out_valid),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic rst, q0, q1, input logic [W-1:0] a, b,
                               input logic e0, e1, ev, input logic [W-1:0] eo);
      vec_t v;
      v.rst = rst; v.q0 = q0; v.q1 = q1; v.a = a; v.b = b;
      v.e0 = e0; v.e1 = e1; v.ev = ev; v.eo = eo;
      return v;
   endfunction

   task automatic model_edge(input logic rst, q0, q1, input logic [W-1:0] a, b);
      logic [1:0] rq;
      int         nw, x;
      rq = {q1, q0};
      if (!rst) begin
         m_owner = -1; m_run = 0; m_last = 1; m_ov = 1'b0; m_od = '0;
         return;
      end
      if (m_owner >= 0 && rq[m_owner]) begin
         m_ov = 1'b1;
         m_od = (m_owner == 0) ? a : b;
      end else begin
         m_ov = 1'b0;
      end
      if (m_owner < 0) begin
         if (q0 && q1)  nw = 1 - m_last;
         else if (q0)   nw = 0;
         else if (q1)   nw = 1;
         else           nw = -1;
      end else begin
         x = 1 - m_owner;
         if (!rq[m_owner]) begin
            nw = rq[x] ? x : -1;
            m_last = m_owner;
         end else if (rq[x] && m_run >= MAX_HOLD) begin
            nw = x;
            m_last = m_owner;
         end else begin
            nw = m_owner;
         end
      end
      m_run   = (nw < 0) ? 0 : ((nw == m_owner) ? m_run + 1 : 1);
      m_owner = nw;
   endtask

   // One clock: drive inputs, advance model at the edge, check on the falling edge.
   task automatic step(input logic rst, q0, q1, input logic [W-1:0] a, b);
      rst_n = rst; req0 = q0; req1 = q1; d0 = a; d1 = b;
      @(posedge clk);
      model_edge(rst, q0, q1, a, b);
      @(negedge clk);
      chk("model_gnt0", 32'(gnt0), 32'(m_owner == 0));
      chk("model_gnt1", 32'(gnt1), 32'(m_owner == 1));
      chk("model_valid", 32'(out_valid), 32'(m_ov));
      chk("model_data", 32'(out_data), 32'(m_od));
      chk("inv_onehot", 32'(gnt0 & gnt1), 32'd0);
      chk("inv_sel", 32'(sel), 32'(gnt1));
   endtask

   task automatic chk_exp(input string tag, input logic e0, e1, ev, input logic [W-1:0] eo);
      chk({tag, "_gnt0"}, 32'(gnt0), 32'(e0));
      chk({tag, "_gnt1"}, 32'(gnt1), 32'(e1));
      chk({tag, "_valid"}, 32'(out_valid), 32'(ev));
      chk({tag, "_data"}, 32'(out_data), 32'(eo));
   endtask

   initial begin
      logic         q0, q1, rst, g1k, g1p;
      logic [W-1:0] eo;
      rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; d0 = '0; d1 = '0;
      m_owner = -1; m_run = 0; m_last = 1; m_ov = 1'b0; m_od = '0;

      // rst q0 q1  d0     d1     gnt0 gnt1 valid data
      tbl[0]  = mk(0, 1, 1, 8'hAA, 8'h55, 0, 0, 0, 8'h00);
      tbl[1]  = mk(0, 1, 1, 8'hAA, 8'h55, 0, 0, 0, 8'h00);
      tbl[2]  = mk(1, 1, 1, 8'hAA, 8'h55, 1, 0, 0, 8'h00);
      tbl[3]  = mk(1, 0, 0, 8'hAA, 8'h55, 0, 0, 0, 8'h00);
      tbl[4]  = mk(1, 1, 0, 8'h01, 8'h00, 1, 0, 0, 8'h00);
      for (int i = 5; i <= 9; i++) tbl[i] = mk(1, 1, 0, 8'h01, 8'h00, 1, 0, 1, 8'h01);
      tbl[10] = mk(1, 0, 0, 8'h01, 8'h00, 0, 0, 0, 8'h01);
      tbl[11] = mk(1, 1, 0, 8'h11, 8'h22, 1, 0, 0, 8'h01);
      for (int i = 12; i <= 14; i++) tbl[i] = mk(1, 1, 1, 8'h11, 8'h22, 1, 0, 1, 8'h11);
      tbl[15] = mk(1, 0, 1, 8'h11, 8'h22, 0, 1, 0, 8'h11);
      tbl[16] = mk(1, 0, 1, 8'h11, 8'h22, 0, 1, 1, 8'h22);
      tbl[17] = mk(1, 0, 0, 8'h11, 8'h22, 0, 0, 0, 8'h22);
      tbl[18] = mk(1, 1, 1, 8'h33, 8'h44, 1, 0, 0, 8'h22);
      tbl[19] = mk(1, 0, 0, 8'h33, 8'h44, 0, 0, 0, 8'h22);
      tbl[20] = mk(1, 1, 1, 8'h33, 8'h44, 0, 1, 0, 8'h22);
      tbl[21] = mk(1, 1, 0, 8'h33, 8'h44, 1, 0, 0, 8'h22);
      tbl[22] = mk(1, 1, 0, 8'h33, 8'h44, 1, 0, 1, 8'h33);
      tbl[23] = mk(1, 0, 0, 8'h33, 8'h44, 0, 0, 0, 8'h33);

      @(negedge clk);
      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].q0, tbl[i].q1, tbl[i].a, tbl[i].b);
         chk_exp($sformatf("vec%0d", i), tbl[i].e0, tbl[i].e1, tbl[i].ev, tbl[i].eo);
      end

      // Contention from IDLE with last released = 0: G1 first, rotating every MAX_HOLD.
      g1p = 1'b0;
      for (int k = 1; k <= 19; k++) begin
         step(1, 1, 1, 8'h00, 8'hFF);
         g1k = (((k - 1) / MAX_HOLD) % 2) == 0;
         eo  = (k == 1) ? 8'h33 : (g1p ? 8'hFF : 8'h00);
         chk_exp($sformatf("rot%0d", k), !g1k, g1k, k >= 2, eo);
         g1p = g1k;
      end

      // Reset while in G1 partway through its hold: grant drops, G0 wins afterwards.
      step(0, 1, 1, 8'h5A, 8'hA5);
      chk_exp("rstmid", 0, 0, 0, 8'h00);
      step(1, 1, 1, 8'h5A, 8'hA5);
      chk_exp("rstmid_regrant", 1, 0, 0, 8'h00);
      step(1, 1, 1, 8'h5A, 8'hA5);
      chk_exp("rstmid_data", 1, 0, 1, 8'h5A);

      // Random traffic; requesters keep req until granted, as the protocol demands.
      q0 = 1'b1; q1 = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 63) != 0);
         if (!(q0 && m_owner != 0))
            q0 = (m_owner == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
         if (!(q1 && m_owner != 1))
            q1 = (m_owner == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
         step(rst, q0, q1, W'($urandom), W'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
